// File: rtl/johnson_ring_decoder.sv
// Decodes a 5-bit Johnson or ring counter value to a phase index.
// Ports: clk, rst (sync, active-high), js_rg (1 = Johnson), count;
//   outputs phase, phase_valid, illegal, seq_err, wrap, mode_chg,
//   locked, err_cnt (saturating seq_err count).
module johnson_ring_decoder #(
    parameter int LOCK_DEPTH = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             js_rg,
    input  logic [4:0]       count,
    output logic [3:0]       phase,
    output logic             phase_valid,
    output logic             illegal,
    output logic             seq_err,
    output logic             wrap,
    output logic             mode_chg,
    output logic             locked,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        ACQ,
        LOCK
    } state_t;

    localparam logic [2:0] LD = LOCK_DEPTH[2:0];

    state_t     state;
    state_t     state_next;
    logic [2:0] lock_cnt;
    logic [2:0] lock_cnt_next;
    logic [3:0] prev_phase;
    logic       prev_mode;

    logic       legal;
    logic [3:0] dec_phase;
    logic [3:0] last_phase;
    logic [3:0] succ_phase;
    logic       is_succ;
    logic       chg;
    logic       seq_next;
    logic       wrap_next;
    logic       chg_next;

    always_comb begin
        legal     = 1'b0;
        dec_phase = 4'd0;
        if (js_rg) begin
            case (count)
                5'b00000: begin legal = 1'b1; dec_phase = 4'd0; end
                5'b00001: begin legal = 1'b1; dec_phase = 4'd1; end
                5'b00011: begin legal = 1'b1; dec_phase = 4'd2; end
                5'b00111: begin legal = 1'b1; dec_phase = 4'd3; end
                5'b01111: begin legal = 1'b1; dec_phase = 4'd4; end
                5'b11111: begin legal = 1'b1; dec_phase = 4'd5; end
                5'b11110: begin legal = 1'b1; dec_phase = 4'd6; end
                5'b11100: begin legal = 1'b1; dec_phase = 4'd7; end
                5'b11000: begin legal = 1'b1; dec_phase = 4'd8; end
                5'b10000: begin legal = 1'b1; dec_phase = 4'd9; end
                default:  begin legal = 1'b0; dec_phase = 4'd0; end
            endcase
        end else begin
            case (count)
                5'b00001: begin legal = 1'b1; dec_phase = 4'd0; end
                5'b00010: begin legal = 1'b1; dec_phase = 4'd1; end
                5'b00100: begin legal = 1'b1; dec_phase = 4'd2; end
                5'b01000: begin legal = 1'b1; dec_phase = 4'd3; end
                5'b10000: begin legal = 1'b1; dec_phase = 4'd4; end
                default:  begin legal = 1'b0; dec_phase = 4'd0; end
            endcase
        end
    end

    // Decoding is one-to-one, so matching the successor phase is the
    // same as matching the successor code.
    always_comb begin
        last_phase = js_rg ? 4'd9 : 4'd4;
        succ_phase = (prev_phase == last_phase) ? 4'd0
                                                : prev_phase + 4'd1;
        is_succ    = legal && (dec_phase == succ_phase);
        chg        = (js_rg != prev_mode);
    end

    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        seq_next      = 1'b0;
        wrap_next     = 1'b0;
        chg_next      = 1'b0;
        unique case (state)
            IDLE: begin
                state_next    = ACQ;
                lock_cnt_next = 3'd0;
            end
            ACQ: begin
                chg_next = chg;
                if (chg || !legal) begin
                    lock_cnt_next = 3'd0;
                end else if (is_succ) begin
                    if (lock_cnt + 3'd1 == LD) begin
                        state_next    = LOCK;
                        lock_cnt_next = 3'd0;
                    end else begin
                        lock_cnt_next = lock_cnt + 3'd1;
                    end
                end else begin
                    lock_cnt_next = 3'd0;
                end
            end
            LOCK: begin
                chg_next = chg;
                if (chg) begin
                    state_next    = ACQ;
                    lock_cnt_next = 3'd0;
                end else if (!is_succ) begin
                    seq_next      = 1'b1;
                    state_next    = ACQ;
                    lock_cnt_next = 3'd0;
                end else begin
                    // A successor of the last phase is always phase 0.
                    wrap_next = (prev_phase == last_phase);
                end
            end
            default: begin
                state_next    = IDLE;
                lock_cnt_next = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            lock_cnt    <= 3'd0;
            prev_phase  <= 4'd0;
            prev_mode   <= 1'b0;
            phase       <= 4'd0;
            phase_valid <= 1'b0;
            illegal     <= 1'b0;
            seq_err     <= 1'b0;
            wrap        <= 1'b0;
            mode_chg    <= 1'b0;
            locked      <= 1'b0;
            err_cnt     <= '0;
        end else begin
            state       <= state_next;
            lock_cnt    <= lock_cnt_next;
            prev_phase  <= dec_phase;
            prev_mode   <= js_rg;
            phase       <= dec_phase;
            phase_valid <= legal;
            illegal     <= !legal;
            seq_err     <= seq_next;
            wrap        <= wrap_next;
            mode_chg    <= chg_next;
            locked      <= (state_next == LOCK);
            if (seq_next && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_johnson_ring_decoder.sv
// Scoreboard bench for johnson_ring_decoder: directed scenarios plus
// random streams, checked against a behavioural model of the decoder.
module tb_johnson_ring_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       js_rg = 1'b1;
    logic [4:0] count = 5'd0;
    logic [3:0] phase;
    logic       phase_valid;
    logic       illegal;
    logic       seq_err;
    logic       wrap;
    logic       mode_chg;
    logic       locked;
    logic [7:0] err_cnt;

    johnson_ring_decoder #(
        .LOCK_DEPTH(2),
        .ERR_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .js_rg      (js_rg),
        .count      (count),
        .phase      (phase),
        .phase_valid(phase_valid),
        .illegal    (illegal),
        .seq_err    (seq_err),
        .wrap       (wrap),
        .mode_chg   (mode_chg),
        .locked     (locked),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] ph;
        logic       pv;
        logic       ill;
        logic       seq;
        logic       wr;
        logic       mc;
        logic       lk;
        logic [7:0] err;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model state
    bit   have_prev = 0;
    bit   m_locked  = 0;
    int   streak    = 0;
    int   errs      = 0;
    int   pph       = 0;
    bit   pmode     = 0;

    function automatic logic [4:0] code_of(input bit js, input int i);
        int v;
        if (js) begin
            if (i <= 5) v = (1 << i) - 1;
            else v = (31 << (i - 5)) & 31;
        end else begin
            v = 1 << i;
        end
        return v[4:0];
    endfunction

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit r, input bit js, input logic [4:0] c);
        exp_t e;
        int   n;
        int   ph;
        bit   lg;
        bit   mc;
        @(negedge clk);
        rst   = r;
        js_rg = js;
        count = c;
        e     = '0;
        if (r) begin
            have_prev = 0;
            m_locked  = 0;
            streak    = 0;
            errs      = 0;
        end else begin
            n  = js ? 10 : 5;
            lg = 0;
            ph = 0;
            for (int i = 0; i < n; i++) begin
                if (code_of(js, i) == c) begin
                    lg = 1;
                    ph = i;
                end
            end
            mc = have_prev && (js != pmode);
            if (have_prev) begin
                if (m_locked) begin
                    if (mc) begin
                        m_locked = 0;
                        streak   = 0;
                    end else if (!(lg && ph == (pph + 1) % n)) begin
                        e.seq    = 1;
                        errs     = (errs < 255) ? errs + 1 : 255;
                        m_locked = 0;
                        streak   = 0;
                    end else begin
                        e.wr = (pph == n - 1) && (ph == 0);
                    end
                end else begin
                    if (mc || !lg) begin
                        streak = 0;
                    end else if (ph == (pph + 1) % n) begin
                        streak++;
                        if (streak == 2) begin
                            m_locked = 1;
                            streak   = 0;
                        end
                    end else begin
                        streak = 0;
                    end
                end
            end
            have_prev = 1;
            pph       = ph;
            pmode     = js;
            e.ph      = ph[3:0];
            e.pv      = lg;
            e.ill     = !lg;
            e.mc      = mc;
        end
        e.lk  = m_locked;
        e.err = errs[7:0];
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("phase", 16'(phase), 16'(e.ph));
                chk("phase_valid", 16'(phase_valid), 16'(e.pv));
                chk("illegal", 16'(illegal), 16'(e.ill));
                chk("seq_err", 16'(seq_err), 16'(e.seq));
                chk("wrap", 16'(wrap), 16'(e.wr));
                chk("mode_chg", 16'(mode_chg), 16'(e.mc));
                chk("locked", 16'(locked), 16'(e.lk));
                chk("err_cnt", 16'(err_cnt), 16'(e.err));
            end
        end
    end

    initial begin : driver
        bit cur_js;
        int n;
        int r;
        step(1, 1, 5'd0);
        step(1, 1, 5'd0);
        // Johnson stream from 00000 through one wrap
        for (int i = 0; i < 13; i++) step(0, 1, code_of(1, i % 10));
        // Mode switch to ring on a Johnson-only code
        step(0, 0, 5'b00111);
        for (int i = 0; i < 3; i++) step(0, 0, code_of(0, i));
        // Repeated code while locked in ring mode
        step(0, 0, 5'b01000);
        step(0, 0, 5'b01000);
        // Illegal in ACQ
        step(0, 0, 5'b10101);
        // Drive err_cnt into saturation
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < 3; i++) step(0, 0, code_of(0, i));
            step(0, 0, code_of(0, 2));
        end
        step(1, 0, 5'd0);
        // Reset while locked at Johnson phase 6
        for (int i = 0; i < 7; i++) step(0, 1, code_of(1, i));
        step(1, 1, 5'd0);
        step(0, 1, code_of(1, 7));
        step(0, 1, code_of(1, 8));
        // Random streams, mostly legal successions
        cur_js = 1;
        for (int k = 0; k < 3000; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                step(1, cur_js, 5'($urandom));
            end else if (r < 6) begin
                cur_js = ~cur_js;
                step(0, cur_js, 5'($urandom));
            end else if (r < 14) begin
                step(0, cur_js, 5'($urandom));
            end else begin
                n = cur_js ? 10 : 5;
                step(0, cur_js, code_of(cur_js, (pph + 1) % n));
            end
        end
        repeat (4) @(posedge clk);
        #2;
        chk("scoreboard_drained", 16'(q.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
